// File: rtl/posit_pio_sequencer_if.sv
// Core-side operand/result handshake between the PIO sequencer (master) and the posit core (slave).
// Purely a wiring bundle: no state, no added latency.
// Backpressure: valid/ready on both the operand and the result channels.
interface posit_pio_sequencer_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] core_num1;
    logic [WIDTH-1:0] core_num2;
    logic [2:0]       core_op;
    logic             core_in_valid;
    logic             core_in_ready;
    logic             core_out_valid;
    logic [WIDTH-1:0] core_out;
    logic             core_out_ready;

    modport master (
        output core_num1, core_num2, core_op, core_in_valid, core_out_ready,
        input  core_in_ready, core_out_valid, core_out
    );

    modport slave (
        input  core_num1, core_num2, core_op, core_in_valid, core_out_ready,
        output core_in_ready, core_out_valid, core_out
    );
endinterface

// File: rtl/posit_pio_sequencer.sv
// Turns level PIO writes into one toggle-acknowledged posit operation on the core; POSIT_SEQ_TIMEOUT_EN adds a WAIT watchdog.
// Latency: request-to-ack 4 cycles minimum; illegal opcode acks 2 cycles after the request.
// Backpressure: operands held stable until core_in_ready; results accepted in WAIT, late ones dropped in IDLE.
module posit_pio_sequencer #(
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    input  logic [WIDTH-1:0] num1_export,
    input  logic [WIDTH-1:0] num2_export,
    input  logic [3:0]       cmd_export,
    output logic [WIDTH-1:0] result_export,
    output logic [7:0]       status_export,
    posit_pio_sequencer_if.master core
);
    typedef enum logic [2:0] {S_PRIME, S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    localparam logic [WIDTH-1:0] NAR = {1'b1, {(WIDTH-1){1'b0}}};

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t           state, state_nxt;
    logic             ack, req_tgl, ill_pend, st_illegal, st_stale, st_timeout_bit;
    logic [2:0]       last_op;
    logic [WIDTH-1:0] cap_res;
    logic             req, op_legal, wd_expire, busy;

    assign req      = (state == S_IDLE) && (cmd_export[0] != ack);
    assign op_legal = (cmd_export[3:1] <= 3'd4);

`ifdef POSIT_SEQ_TIMEOUT_EN
    localparam int               WD_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_cnt;
    logic            to_pend, st_timeout;

    // Fires on the last permitted WAIT cycle, so WAIT lasts exactly TIMEOUT_CYCLES.
    assign wd_expire      = (state == S_WAIT) && (wd_cnt == WD_LAST);
    assign st_timeout_bit = st_timeout;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            wd_cnt     <= '0;
            to_pend    <= 1'b0;
            st_timeout <= 1'b0;
        end else begin
            if (state == S_ISSUE)
                wd_cnt <= '0;
            else if (state == S_WAIT)
                wd_cnt <= wd_cnt + 1'b1;

            if (req)
                to_pend <= 1'b0;
            else if (wd_expire && !core.core_out_valid)
                to_pend <= 1'b1;

            if (req)
                st_timeout <= 1'b0;
            else if (state == S_DONE)
                st_timeout <= to_pend;
        end
    end
`else
    assign wd_expire      = 1'b0;
    assign st_timeout_bit = 1'b0;
`endif

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n)
            state <= S_PRIME;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_PRIME: state_nxt = S_IDLE;
            S_IDLE:  if (req) state_nxt = op_legal ? S_ISSUE : S_DONE;
            S_ISSUE: if (core.core_in_ready) state_nxt = S_WAIT;
            S_WAIT:  if (core.core_out_valid || wd_expire) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_PRIME;
        endcase
    end

    always_comb begin
        core.core_in_valid  = 1'b0;
        core.core_out_ready = 1'b0;
        busy                = 1'b0;
        case (state)
            S_IDLE:  core.core_out_ready = 1'b1;
            S_ISSUE: begin core.core_in_valid = 1'b1; busy = 1'b1; end
            S_WAIT:  begin core.core_out_ready = 1'b1; busy = 1'b1; end
            S_DONE:  busy = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            ack            <= 1'b0;
            req_tgl        <= 1'b0;
            ill_pend       <= 1'b0;
            st_illegal     <= 1'b0;
            st_stale       <= 1'b0;
            last_op        <= 3'd0;
            cap_res        <= '0;
            result_export  <= '0;
            core.core_num1 <= '0;
            core.core_num2 <= '0;
            core.core_op   <= 3'd0;
        end else begin
            case (state)
                // Absorb whatever toggle survived reset so it is never executed.
                S_PRIME: ack <= cmd_export[0];
                S_IDLE: if (req) begin
                    core.core_num1 <= num1_export;
                    core.core_num2 <= num2_export;
                    core.core_op   <= cmd_export[3:1];
                    req_tgl        <= cmd_export[0];
                    ill_pend       <= !op_legal;
                    st_illegal     <= 1'b0;
                    cap_res        <= NAR;
                end
                S_WAIT: if (core.core_out_valid) cap_res <= core.core_out;
                S_DONE: begin
                    result_export <= cap_res;
                    last_op       <= core.core_op;
                    ack           <= req_tgl;
                    st_illegal    <= ill_pend;
                end
                default: ;
            endcase

            // A result arriving in IDLE has no owner; flag it rather than lose it silently.
            if (state == S_IDLE && core.core_out_valid)
                st_stale <= 1'b1;
            else if (req)
                st_stale <= 1'b0;
        end
    end

    assign status_export = {last_op, st_stale, st_timeout_bit, st_illegal, busy, ack};
endmodule
